// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: definitions shared by the accumulator CPU front end.
//   - Instruction field widths (INSTR_W, OPC_W, OPR_W)
//   - Opcode constants OP_HLT (000) .. OP_JMP (111)
//   - fetch_state_t: the fetch FSM state encoding. ST_BRK exists only when
//     IF_BREAKPOINT_EN is defined.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W = 8;
    localparam int OPC_W   = 3;
    localparam int OPR_W   = 5;

    localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_LDA = 3'b101;
    localparam logic [OPC_W-1:0] OP_STO = 3'b110;
    localparam logic [OPC_W-1:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_WAIT,
        ST_EXEC,
        ST_WAIT_EXEC,
        ST_HALT
`ifdef IF_BREAKPOINT_EN
        , ST_BRK
`endif
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if: loader handshake plus program-memory instruction port.
//   Loader : ld_valid, ld_data (to fetch), ld_ready (from fetch)
//   Memory : mem_addr, mem_wr_en, mem_wr_data, mem_rd_en (from fetch),
//            mem_rd_data (to fetch)
//   master : the fetch unit side
//   slave  : the loader / program memory side
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_W = 5
);
    logic                        ld_valid;
    logic [cpu_pkg::INSTR_W-1:0] ld_data;
    logic                        ld_ready;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_wr_en;
    logic [cpu_pkg::INSTR_W-1:0] mem_wr_data;
    logic                        mem_rd_en;
    logic [cpu_pkg::INSTR_W-1:0] mem_rd_data;

    modport master (
        input  ld_valid, ld_data, mem_rd_data,
        output ld_ready, mem_addr, mem_wr_en, mem_wr_data, mem_rd_en
    );

    modport slave (
        output ld_valid, ld_data, mem_rd_data,
        input  ld_ready, mem_addr, mem_wr_en, mem_wr_data, mem_rd_en
    );
endinterface

// File: rtl/pc_next.sv
// ---------------------------------------------------------------------------
// pc_next: combinational next-PC for the instruction in EXEC.
//   pc       in  ADDR_W  current PC
//   opcode   in  3       IR opcode field
//   operand  in  5       IR operand field (JMP target)
//   acc_zero in  1       accumulator is zero (SKZ condition)
//   next_pc  out ADDR_W  PC for the following fetch (wraps modulo 2^ADDR_W)
// ---------------------------------------------------------------------------
module pc_next
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [OPR_W-1:0]  operand,
    input  logic              acc_zero,
    output logic [ADDR_W-1:0] next_pc
);

    // JMP target: operand zero-extended or truncated to the PC width.
    logic [ADDR_W-1:0] jmp_target;

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_jmp
            if (gi < OPR_W) begin : g_bit
                assign jmp_target[gi] = operand[gi];
            end else begin : g_zero
                assign jmp_target[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        next_pc = pc + ADDR_W'(1);
        case (opcode)
            OP_JMP:  next_pc = jmp_target;
            OP_SKZ:  next_pc = acc_zero ? (pc + ADDR_W'(2)) : (pc + ADDR_W'(1));
            OP_HLT:  next_pc = pc;
            default: next_pc = pc + ADDR_W'(1);
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch: front end of the 8-bit accumulator CPU. Owns PC, IR and the
// program-memory instruction port; loads programs in load mode and fetches /
// resolves HLT, SKZ and JMP in run mode.
//   clock, reset   clock and asynchronous active-high reset
//   load_in        1 = program load mode, 0 = run
//   bus (master)   loader handshake + program memory port
//   acc_zero       accumulator == 0, used by SKZ in EXEC
//   opcode/operand IR fields (opcode is 000 outside EXEC/WAIT_EXEC)
//   instr_valid    one-cycle pulse in EXEC
//   halted         high in HALT
//   pc             current program counter
// Optional (macro IF_BREAKPOINT_EN): bp_addr, bp_en, bp_resume in; bp_hit out.
// ---------------------------------------------------------------------------
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_in,
    instr_fetch_if.master     bus,
    input  logic              acc_zero,
    output logic [OPC_W-1:0]  opcode,
    output logic [OPR_W-1:0]  operand,
    output logic              instr_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
`ifdef IF_BREAKPOINT_EN
    ,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_en,
    input  logic              bp_resume,
    output logic              bp_hit
`endif
);

    localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

    fetch_state_t         state_reg, state_next;
    logic [ADDR_W-1:0]    pc_reg, pc_next_val;
    logic [ADDR_W-1:0]    load_addr_reg, load_addr_next;
    logic [INSTR_W-1:0]   ir_reg, ir_next;
    logic [1:0]           wait_cnt_reg, wait_cnt_next;
    logic [ADDR_W-1:0]    exec_pc;
`ifdef IF_BREAKPOINT_EN
    logic                 bp_skip_reg, bp_skip_next;
`endif

    pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc       (pc_reg),
        .opcode   (ir_reg[INSTR_W-1 -: OPC_W]),
        .operand  (ir_reg[OPR_W-1:0]),
        .acc_zero (acc_zero),
        .next_pc  (exec_pc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            load_addr_reg <= '0;
            ir_reg        <= '0;
            wait_cnt_reg  <= '0;
`ifdef IF_BREAKPOINT_EN
            bp_skip_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next_val;
            load_addr_reg <= load_addr_next;
            ir_reg        <= ir_next;
            wait_cnt_reg  <= wait_cnt_next;
`ifdef IF_BREAKPOINT_EN
            bp_skip_reg   <= bp_skip_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next_val     = pc_reg;
        load_addr_next  = load_addr_reg;
        ir_next         = ir_reg;
        wait_cnt_next   = wait_cnt_reg;
        bus.ld_ready    = 1'b0;
        bus.mem_addr    = pc_reg;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = '0;
        bus.mem_rd_en   = 1'b0;
        opcode          = '0;
        instr_valid     = 1'b0;
        halted          = 1'b0;
`ifdef IF_BREAKPOINT_EN
        bp_skip_next    = bp_skip_reg;
        bp_hit          = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: state_next = load_in ? ST_LOAD : ST_FETCH;

            ST_LOAD: begin
                // ld_ready follows load_in so a byte offered on the exit
                // cycle is never written.
                if (load_in) begin
                    bus.ld_ready = 1'b1;
                    bus.mem_addr = load_addr_reg;
                    if (bus.ld_valid) begin
                        bus.mem_wr_en   = 1'b1;
                        bus.mem_wr_data = bus.ld_data;
                        load_addr_next  = load_addr_reg + ADDR_W'(1);
                    end
                end else begin
                    pc_next_val    = '0;
                    load_addr_next = '0;
                    state_next     = ST_FETCH;
                end
            end

            ST_FETCH: begin
`ifdef IF_BREAKPOINT_EN
                if (bp_en && (pc_reg == bp_addr) && !bp_skip_reg) begin
                    state_next = ST_BRK;
                end else begin
                    bus.mem_rd_en = 1'b1;
                    bp_skip_next  = 1'b0;
                    wait_cnt_next = '0;
                    state_next    = ST_WAIT;
                end
`else
                bus.mem_rd_en = 1'b1;
                wait_cnt_next = '0;
                state_next    = ST_WAIT;
`endif
            end

            ST_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    ir_next    = bus.mem_rd_data;
                    state_next = ST_EXEC;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 2'd1;
                end
            end

            ST_EXEC: begin
                instr_valid = 1'b1;
                opcode      = ir_reg[INSTR_W-1 -: OPC_W];
                pc_next_val = exec_pc;
                state_next  = (ir_reg[INSTR_W-1 -: OPC_W] == OP_HLT) ? ST_HALT
                                                                     : ST_WAIT_EXEC;
            end

            ST_WAIT_EXEC: begin
                opcode     = ir_reg[INSTR_W-1 -: OPC_W];
                state_next = ST_FETCH;
            end

            ST_HALT: halted = 1'b1;

`ifdef IF_BREAKPOINT_EN
            ST_BRK: begin
                bp_hit = 1'b1;
                if (bp_resume) begin
                    bp_skip_next = 1'b1;
                    state_next   = ST_FETCH;
                end
            end
`endif

            default: state_next = ST_IDLE;
        endcase

        // Load request wins over any run state: drop the in-flight fetch,
        // keep PC/IR as they were and restart loading at address 0.
        if (load_in && (state_reg != ST_LOAD)) begin
            state_next     = ST_LOAD;
            load_addr_next = '0;
            pc_next_val    = pc_reg;
            ir_next        = ir_reg;
            instr_valid    = 1'b0;
            opcode         = '0;
            bus.mem_rd_en  = 1'b0;
        end
    end

    assign operand = ir_reg[OPR_W-1:0];
    assign pc      = pc_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch: self-checking bench for instr_fetch (ADDR_W=5, MEM_LAT=1).
// Scoreboard queues hold expected writes, fetch addresses and EXEC fields;
// a negedge monitor pops and compares them as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic       clock;
    logic       reset;
    logic       load_in;
    logic       acc_zero;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       instr_valid;
    logic       halted;
    logic [4:0] pc;

    instr_fetch_if #(.ADDR_W(5)) bus ();

    instr_fetch #(.ADDR_W(5), .MEM_LAT(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_in     (load_in),
        .bus         (bus),
        .acc_zero    (acc_zero),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .halted      (halted),
        .pc          (pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Program memory model, one-cycle read latency.
    logic [7:0] mem [32];
    always @(posedge clock) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    end

    typedef struct packed {logic [4:0] addr; logic [7:0] data;} wr_t;
    typedef struct packed {logic [2:0] opc; logic [4:0] opr;} ex_t;
    typedef struct {
        logic [7:0] instr;
        logic [4:0] at_pc;
        logic       az;
        logic [4:0] exp_next;
    } vec_t;

    wr_t        wq[$];
    logic [4:0] fq[$];
    ex_t        eq[$];
    int         total = 0;
    int         bad   = 0;
    bit         no_exec = 1'b0;
    logic [7:0] img [32];
    vec_t       vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: compares DUT activity against the scoreboard queues.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.mem_wr_en && bus.mem_rd_en) begin
                total++; bad++;
                $display("FAIL rw_exclusive addr=%0d", bus.mem_addr);
            end
            if (bus.mem_wr_en) begin
                wr_t w;
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected got addr=%0d data=%h", bus.mem_addr, bus.mem_wr_data);
                end else begin
                    w = wq.pop_front();
                    if (bus.mem_addr !== w.addr || bus.mem_wr_data !== w.data) begin
                        bad++;
                        $display("FAIL wr got addr=%0d data=%h exp addr=%0d data=%h",
                                 bus.mem_addr, bus.mem_wr_data, w.addr, w.data);
                    end
                    $display("write addr=%0d data=%h", bus.mem_addr, bus.mem_wr_data);
                end
            end
            if (bus.mem_rd_en && fq.size() != 0) begin
                logic [4:0] a;
                a = fq.pop_front();
                total++;
                if (bus.mem_addr !== a) begin
                    bad++;
                    $display("FAIL fetch_addr got=%0d exp=%0d", bus.mem_addr, a);
                end else $display("fetch addr=%0d", a);
            end
            if (instr_valid) begin
                if (no_exec) begin
                    total++; bad++;
                    $display("FAIL exec_after_abort got opcode=%0d", opcode);
                end else if (eq.size() != 0) begin
                    ex_t e;
                    e = eq.pop_front();
                    total++;
                    if (opcode !== e.opc || operand !== e.opr) begin
                        bad++;
                        $display("FAIL exec got opc=%0d opr=%0d exp opc=%0d opr=%0d",
                                 opcode, operand, e.opc, e.opr);
                    end else $display("exec opc=%0d opr=%0d pc=%0d", opcode, operand, pc);
                end
            end
        end
    end

    task automatic wait_empty(input int cycles, input string name);
        int k;
        k = 0;
        while ((fq.size() != 0 || eq.size() != 0 || wq.size() != 0) && k < cycles) begin
            @(posedge clock); #1;
            k++;
        end
        total++;
        if (fq.size() != 0 || eq.size() != 0 || wq.size() != 0) begin
            bad++;
            $display("FAIL %s timeout pending fq=%0d eq=%0d wq=%0d exp 0", name,
                     fq.size(), eq.size(), wq.size());
            fq.delete(); eq.delete(); wq.delete();
        end
    endtask

    // Raise load_in, wait for LOAD, stream img[0..n-1]; load_in stays high.
    task automatic load_image(input int n);
        int k;
        load_in = 1'b1;
        k = 0;
        while (!bus.ld_ready && k < 10) begin
            @(posedge clock); #1;
            k++;
        end
        check("load_ready", 32'(bus.ld_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = img[i];
            wq.push_back('{addr: 5'(i), data: img[i]});
            @(posedge clock); #1;
        end
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
    endtask

    task automatic wait_halted(input string name);
        int k;
        k = 0;
        while (!halted && k < 40) begin
            @(posedge clock); #1;
            k++;
        end
        check(name, 32'(halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        vecs[0] = '{8'h20, 5'd5,  1'b1, 5'd7};
        vecs[1] = '{8'h20, 5'd5,  1'b0, 5'd6};
        vecs[2] = '{8'h40, 5'd31, 1'b0, 5'd0};
        vecs[3] = '{8'h20, 5'd31, 1'b1, 5'd1};
        vecs[4] = '{8'h20, 5'd31, 1'b0, 5'd0};
        vecs[5] = '{8'hE9, 5'd10, 1'b0, 5'd9};
        vecs[6] = '{8'hC0, 5'd17, 1'b1, 5'd18};
        vecs[7] = '{8'h7F, 5'd30, 1'b1, 5'd31};

        reset        = 1'b1;
        load_in      = 1'b1;
        acc_zero     = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        repeat (2) @(negedge clock);
        check("rst_pc",        32'(pc),            32'd0);
        check("rst_opcode",    32'(opcode),        32'd0);
        check("rst_operand",   32'(operand),       32'd0);
        check("rst_valid",     32'(instr_valid),   32'd0);
        check("rst_halted",    32'(halted),        32'd0);
        check("rst_ld_ready",  32'(bus.ld_ready),  32'd0);
        check("rst_wr_en",     32'(bus.mem_wr_en), 32'd0);
        check("rst_rd_en",     32'(bus.mem_rd_en), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Four-byte program: JMP 3 / HLT / HLT / ADD.
        clear_img();
        img[0] = 8'hE3; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h40;
        load_image(4);
        fq.push_back(5'd0); fq.push_back(5'd3); fq.push_back(5'd4);
        eq.push_back('{opc: 3'd7, opr: 5'd3});
        eq.push_back('{opc: 3'd2, opr: 5'd0});
        load_in = 1'b0;
        wait_empty(100, "prog4");
        wait_halted("prog4_halted");
        check("prog4_pc", 32'(pc), 32'd4);

        // HLT at PC=2: stays halted for 20 cycles, then load_in re-enters LOAD.
        clear_img();
        img[0] = 8'hE2;
        load_image(32);
        fq.push_back(5'd0); fq.push_back(5'd2);
        eq.push_back('{opc: 3'd7, opr: 5'd2});
        eq.push_back('{opc: 3'd0, opr: 5'd0});
        load_in = 1'b0;
        wait_empty(100, "hlt");
        wait_halted("hlt_halted");
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("hlt_hold_halted", 32'(halted), 32'd1);
            check("hlt_hold_pc",     32'(pc),     32'd2);
            check("hlt_hold_opcode", 32'(opcode), 32'd0);
        end
        @(posedge clock); #1;
        load_in = 1'b1;
        @(posedge clock); #1;
        check("hlt_to_load_ready", 32'(bus.ld_ready), 32'd1);
        check("hlt_to_load_halted", 32'(halted), 32'd0);

        // Table: JMP to at_pc, execute one instruction, check the next fetch.
        for (int v = 0; v < 8; v++) begin
            clear_img();
            img[0] = 8'hE0 | {3'b000, vecs[v].at_pc};
            img[vecs[v].at_pc] = vecs[v].instr;
            acc_zero = vecs[v].az;
            load_image(32);
            fq.push_back(5'd0); fq.push_back(vecs[v].at_pc); fq.push_back(vecs[v].exp_next);
            eq.push_back('{opc: 3'd7, opr: vecs[v].at_pc});
            eq.push_back('{opc: vecs[v].instr[7:5], opr: vecs[v].instr[4:0]});
            load_in = 1'b0;
            wait_empty(100, "vector");
        end

        // load_in during WAIT: no EXEC, immediate LOAD, first byte at address 0.
        clear_img();
        img[0] = 8'h40;
        load_image(32);
        load_in = 1'b0;
        begin
            int k;
            k = 0;
            @(negedge clock);
            while (!bus.mem_rd_en && k < 20) begin
                @(negedge clock);
                k++;
            end
            check("abort_fetch_seen", 32'(bus.mem_rd_en), 32'd1);
        end
        @(posedge clock); #1;
        no_exec = 1'b1;
        load_in = 1'b1;
        @(posedge clock); #1;
        check("abort_ld_ready", 32'(bus.ld_ready),  32'd1);
        check("abort_opcode",   32'(opcode),        32'd0);
        check("abort_valid",    32'(instr_valid),   32'd0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hAB;
        wq.push_back('{addr: 5'd0, data: 8'hAB});
        @(posedge clock); #1;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        no_exec = 1'b0;
        check("abort_write_done", 32'(wq.size()), 32'd0);
        load_in = 1'b0;
        repeat (6) @(posedge clock);
        #1;

        // Reset in the middle of EXEC at PC=6.
        clear_img();
        img[0] = 8'hE6; img[6] = 8'h40;
        load_image(32);
        fq.push_back(5'd0); fq.push_back(5'd6);
        eq.push_back('{opc: 3'd7, opr: 5'd6});
        eq.push_back('{opc: 3'd2, opr: 5'd0});
        load_in = 1'b0;
        begin
            int k;
            k = 0;
            @(negedge clock);
            while (!(instr_valid && pc == 5'd6) && k < 40) begin
                @(negedge clock);
                k++;
            end
            check("rstx_exec_seen", 32'(instr_valid && pc == 5'd6), 32'd1);
        end
        #2;
        reset = 1'b1;
        #1;
        check("rstx_pc",       32'(pc),             32'd0);
        check("rstx_opcode",   32'(opcode),         32'd0);
        check("rstx_operand",  32'(operand),        32'd0);
        check("rstx_valid",    32'(instr_valid),    32'd0);
        check("rstx_halted",   32'(halted),         32'd0);
        check("rstx_ld_ready", 32'(bus.ld_ready),   32'd0);
        check("rstx_rd_en",    32'(bus.mem_rd_en),  32'd0);
        check("rstx_wr_en",    32'(bus.mem_wr_en),  32'd0);
        check("rstx_addr",     32'(bus.mem_addr),   32'd0);
        @(posedge clock); #1;
        fq.delete(); eq.delete();
        fq.push_back(5'd0);
        reset = 1'b0;
        wait_empty(20, "rstx_refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front end of the 8-bit accumulator CPU; sits directly upstream of the instruction decode/enable controller.
- Owns the program counter (PC), the instruction register (IR) and the instruction port of program memory.
- In load mode, accepts program bytes from an external loader over a valid/ready handshake and writes them to memory.
- In run mode, fetches 8-bit instructions (opcode[7:5], operand[4:0]), presents the opcode to the controller, and resolves HLT, SKZ and JMP locally.

Parameters:
- ADDR_W, 5, program memory address width; PC and load address wrap modulo 2^ADDR_W.
- MEM_LAT, 1, read latency of program memory in cycles; legal values 1..2.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high; clock is clock
- load_in  in  1  high = program load mode, low = run
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_ready  out  1  block accepts a loader byte this cycle
- mem_addr  out  ADDR_W  program memory address
- mem_wr_en  out  1  memory write strobe (load mode only)
- mem_wr_data  out  8  memory write data
- mem_rd_en  out  1  memory read strobe
- mem_rd_data  in  8  memory read data, valid MEM_LAT cycles after mem_rd_en
- acc_zero  in  1  accumulator == 0, sampled in EXEC
- opcode  out  3  IR[7:5]; forced to 000 outside EXEC/WAIT_EXEC
- operand  out  5  IR[4:0]
- instr_valid  out  1  one-cycle pulse in EXEC
- halted  out  1  high in HALT
- pc  out  ADDR_W  current PC

Behaviour:
- Reset: state IDLE; PC=0, load_addr=0, IR=0x00; all outputs 0.
- IDLE: if load_in=1, go to LOAD; otherwise go to FETCH.
- LOAD:
  - ld_ready=1.
  - On ld_valid&&ld_ready: mem_wr_en=1 combinationally, mem_addr=load_addr, mem_wr_data=ld_data; load_addr++ (wraps).
  - On load_in falling: PC=0, load_addr=0, go to FETCH. A byte presented in that same cycle is not accepted, because ld_ready=0 once load_in=0.
- FETCH: mem_rd_en=1, mem_addr=PC; go to WAIT.
- WAIT: count MEM_LAT-1 additional cycles, then IR<=mem_rd_data and go to EXEC. With MEM_LAT=1, IR captures on the cycle after FETCH.
- EXEC: one cycle; instr_valid=1; opcode/operand driven from IR. Next PC:
  - 111 JMP: PC <= operand (zero-extended or truncated to ADDR_W).
  - 001 SKZ: PC <= PC+2 if acc_zero, else PC+1.
  - 000 HLT: PC unchanged; go to HALT.
  - Others (010-110): PC <= PC+1.
  - All non-HLT opcodes then go to WAIT_EXEC.
- WAIT_EXEC: one cycle with opcode held, giving the controller time to register its enables; then go to FETCH. Instruction rate is therefore 4 cycles per instruction at MEM_LAT=1.
- HALT: halted=1, opcode=000; exits only on load_in=1 (to LOAD) or reset.
- Wrap: PC = 2^ADDR_W-1 followed by PC+1 gives 0; SKZ from 2^ADDR_W-1 gives 1.
- load_in rising in any run state:
  - Abort the fetch immediately; the in-flight read data is discarded.
  - instr_valid=0, opcode=000, go to LOAD with load_addr=0.
- mem_wr_en and mem_rd_en are never high in the same cycle.

Optional Feature:
- Macro IF_BREAKPOINT_EN.
- Defined: adds inputs bp_addr[ADDR_W-1:0], bp_en, bp_resume and output bp_hit.
  - On entering FETCH with bp_en && PC==bp_addr, stall in a BRK state: bp_hit=1, opcode=000, no memory read.
  - A bp_resume pulse performs that fetch and suppresses the match for that one fetch.
  - load_in still overrides BRK.
- Undefined: none of these ports exist and there is no BRK state.

Decomposition:
- Shared package cpu_pkg: opcode constants OP_HLT..OP_JMP (000..111), INSTR_W=8, OPC_W=3, OPR_W=5, and the fetch state enum.
- One natural sub-module, pc_next: combinational next-PC from PC, opcode, operand and acc_zero.

Test Plan:
- Load 4 bytes {0xE3, 0x00, 0x00, 0x40} with load_in=1, then drop load_in:
  - writes land at addresses 0..3;
  - first EXEC shows opcode=111, operand=3;
  - next fetch is from address 3 (opcode 010, PC then 4).
- SKZ (0x20) at PC=5 with acc_zero=1 → next fetch address 7; repeat with acc_zero=0 → 6.
- HLT (0x00) at PC=2 → halted=1, opcode=000, PC stays 2 for 20 cycles; raising load_in enters LOAD with ld_ready=1.
- PC=31 with ADDR_W=5 and an ADD instruction → next fetch address 0; SKZ at 31 with acc_zero=1 → next fetch address 1.
- Assert load_in in the WAIT cycle → no EXEC pulse, opcode=000 next cycle, ld_ready=1, and the first loaded byte is written to address 0.
- Assert reset mid-EXEC → all outputs 0 asynchronously; after release with load_in=0, a fetch from address 0 follows.
